mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
Iterative multiply/divide unit for the RV64 execute stage. It sequences MUL/MULW, DIV/DIVU/REM/REMU and their W variants over multiple cycles. It drives the execute-stage stall request (alustall) and holds the result until the pipeline accepts it. It sits beside the single-cycle ALU and receives already-forwarded operands from the execute-stage operand muxes.

Parameters:
XLEN, 64, datapath width in bits (only 64 is supported).
CNT_W, 6, iteration counter width, equal to log2(XLEN).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  valid multi-cycle op presented in execute this cycle
op  in  mdu_op_t (3)  MUL, DIV, DIVU, REM, REMU
word  in  1  W variant: use low 32 bits of operands, sign-extend 32-bit result
a  in  XLEN  forwarded operand rs1
b  in  XLEN  forwarded operand rs2
stall  in  1  execute stage frozen by another cause; result must be held
flush  in  1  kill the in-flight op
busy  out  1  stall request to the hazard unit (alustall)
done  out  1  result valid
result  out  XLEN  product, quotient or remainder

Behaviour:
- Reset values: state=IDLE, counter=0, done=0, result=0, busy=0. A reset mid-operation aborts the op; no result is produced.
- States are IDLE, MUL, DIV and DONE.
- IDLE
  - busy = start & ~flush, combinational, so the stall is raised in the same cycle start arrives.
  - On start, latch operands and op, then go to MUL or DIV.
  - Divide by zero and signed overflow bypass iteration and go directly to DONE.
- Iteration count N: N=64 when word=0, N=32 when word=1.
- Latency: start in cycle 0 gives done=1 in cycle N+1. busy is high in cycles 0..N.
- Special cases give done=1 in cycle 1, with busy high only in cycle 0.
- MUL state: radix-2 shift-add, one partial product per cycle.
  - MUL returns the low XLEN bits of the product.
  - MULW returns the low 32 bits, sign-extended.
  - Signedness does not affect the low bits.
- DIV state: restoring shift-subtract on magnitudes, one quotient bit per cycle.
  - Signed ops take absolute values at latch time.
  - Final sign fixup: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - W ops sign-extend operands from bit 31 for signed ops and zero-extend them for unsigned ops. The 32-bit result is always sign-extended.
- Divide by zero (operand width per word flag):
  - quotient = all ones (−1), sign-extended for W ops.
  - remainder = the dividend, sign-extended for W ops.
- Signed overflow, when the dividend is the most-negative value and the divisor is −1:
  - quotient = the dividend.
  - remainder = 0.
- The counter counts from 0 to N−1. The last iteration is counter==N−1, after which the state moves to DONE.
- DONE state
  - done=1, busy=0, result held stable.
  - If stall=1, remain in DONE with the result unchanged.
  - If stall=0, go to IDLE next cycle; done clears.
  - start seen in DONE is ignored. The next op is accepted only in IDLE, so back-to-back ops have a one-cycle IDLE gap.
- flush
  - In any state, flush moves to IDLE next cycle with done=0. busy is 0 in the flush cycle.
  - flush overrides stall.
  - flush together with start in IDLE: the op is not accepted.
- While in MUL or DIV, start, op, a and b are ignored; only the latched copies are used.

Decomposition:
- The mdu_op_t enum and the MDU_ITER_64/MDU_ITER_32 constants go in the shared pipes package. The decoder sets op and word there.
- Natural sub-module: mdu_div_core, holding the restoring divider datapath, sign fixup and special-case detection.
- The multiply datapath and the FSM stay in mdu_sequencer.

Test Plan:
- MUL a=7, b=−3 (0xFFFF_FFFF_FFFF_FFFD) -> busy cycles 0..64, done in cycle 65, result=0xFFFF_FFFF_FFFF_FFEB.
- DIVW a=0x0000_0000_FFFF_FFF9 (−7 as a word), b=2 -> done in cycle 33, result=0xFFFF_FFFF_FFFF_FFFD (−3). REMW of the same operands -> 0xFFFF_FFFF_FFFF_FFFF (−1).
- Special cases, each with done in cycle 1:
  - DIVU a=5, b=0 -> result=0xFFFF_FFFF_FFFF_FFFF.
  - REM a=0x8000_0000_0000_0000, b=−1 -> result=0.
  - DIV of the same operands -> result=0x8000_0000_0000_0000.
- REMU a=100, b=7 with stall=1 held for 3 cycles after done -> result=2 stable and done high for 4 cycles, then IDLE.
- Start DIV, assert flush in cycle 10 -> IDLE in cycle 11, done never asserted. A following MUL a=6, b=7 -> 42.
- Assert reset in cycle 20 of a DIV -> all outputs 0 next cycle. A new op after reset completes normally.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding, FSM states, iteration counts and a word sign-extension helper.
package mdu_sequencer_pkg;

    localparam int MDU_ITER_64 = 64;
    localparam int MDU_ITER_32 = 32;

    typedef enum logic [2:0] {
        MDU_MUL  = 3'd0,
        MDU_DIV  = 3'd1,
        MDU_DIVU = 3'd2,
        MDU_REM  = 3'd3,
        MDU_REMU = 3'd4
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/mdu_sequencer_div_core.sv
// Restoring shift-subtract divider on operand magnitudes, with sign fixup and
// divide-by-zero / signed-overflow detection on the incoming operands.
module mdu_div_core
    import mdu_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_step,
    input  mdu_op_t     i_op,
    input  logic        i_word,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic        o_special,
    output logic [63:0] o_special_result,
    output logic [63:0] o_result
);

    logic        w_signed;
    logic        w_is_rem;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_a_mag;
    logic [63:0] w_b_mag;
    logic [63:0] w_a_res;
    logic [63:0] w_min;
    logic        w_div0;
    logic        w_ovf;

    logic [63:0] r_rem;
    logic [63:0] r_quo;
    logic [63:0] r_dvsr;
    logic        r_is_rem;
    logic        r_word;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [64:0] w_shift;
    logic [64:0] w_diff;
    logic        w_ge;
    logic [63:0] w_rem_next;
    logic [63:0] w_quo_next;
    logic [63:0] w_q_fix;
    logic [63:0] w_r_fix;
    logic [63:0] w_sel;

    // Operand preparation and special-case detection on the live inputs
    always_comb begin
        w_signed = (i_op == MDU_DIV) | (i_op == MDU_REM);
        w_is_rem = (i_op == MDU_REM) | (i_op == MDU_REMU);
        if (i_word) begin
            w_a_ext = w_signed ? sext32(i_a[31:0]) : {32'd0, i_a[31:0]};
            w_b_ext = w_signed ? sext32(i_b[31:0]) : {32'd0, i_b[31:0]};
            w_min   = 64'hFFFF_FFFF_8000_0000;
            w_a_res = sext32(i_a[31:0]);
        end else begin
            w_a_ext = i_a;
            w_b_ext = i_b;
            w_min   = 64'h8000_0000_0000_0000;
            w_a_res = i_a;
        end
        w_a_neg = w_signed & w_a_ext[63];
        w_b_neg = w_signed & w_b_ext[63];
        w_a_mag = w_a_neg ? (64'd0 - w_a_ext) : w_a_ext;
        w_b_mag = w_b_neg ? (64'd0 - w_b_ext) : w_b_ext;
        w_div0  = (w_b_ext == 64'd0);
        w_ovf   = w_signed & (w_a_ext == w_min) & (w_b_ext == 64'hFFFF_FFFF_FFFF_FFFF);
        o_special = w_div0 | w_ovf;
        if (w_div0) begin
            o_special_result = w_is_rem ? w_a_res : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (w_ovf) begin
            o_special_result = w_is_rem ? 64'd0 : w_a_res;
        end else begin
            o_special_result = 64'd0;
        end
    end

    // One restoring step; the final result is taken from the step's next values
    always_comb begin
        w_shift    = {r_rem, r_quo[63]};
        w_diff     = w_shift - {1'b0, r_dvsr};
        w_ge       = ~w_diff[64];
        w_rem_next = w_ge ? w_diff[63:0] : w_shift[63:0];
        w_quo_next = {r_quo[62:0], w_ge};
        w_q_fix    = r_neg_q ? (64'd0 - w_quo_next) : w_quo_next;
        w_r_fix    = r_neg_r ? (64'd0 - w_rem_next) : w_rem_next;
        w_sel      = r_is_rem ? w_r_fix : w_q_fix;
        o_result   = r_word ? sext32(w_sel[31:0]) : w_sel;
    end

    // Divider state: word dividends are pre-shifted so 32 steps consume them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem    <= 64'd0;
            r_quo    <= 64'd0;
            r_dvsr   <= 64'd0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (i_load) begin
            r_rem    <= 64'd0;
            r_quo    <= i_word ? {w_a_mag[31:0], 32'd0} : w_a_mag;
            r_dvsr   <= w_b_mag;
            r_is_rem <= w_is_rem;
            r_word   <= i_word;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
        end else if (i_step) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
        end else begin
            r_rem <= r_rem;
            r_quo <= r_quo;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIV/REM sequencer for the execute stage: owns the FSM and the
// shift-add multiplier, raises the stall request and holds the result.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  mdu_op_t         op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            stall,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mdu_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_word;
    logic            r_done;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_prod;

    logic            w_accept;
    logic [CNT_W-1:0] w_last;
    logic [XLEN-1:0] w_prod_next;
    logic [XLEN-1:0] w_mul_result;
    logic            w_div_special;
    logic [XLEN-1:0] w_div_special_result;
    logic [XLEN-1:0] w_div_result;

    assign w_accept = (r_state == S_IDLE) & start & ~flush;
    assign busy     = ~reset & ~flush &
                      (((r_state == S_IDLE) & start) | (r_state == S_MUL) | (r_state == S_DIV));
    assign done     = r_done;
    assign result   = r_result;

    mdu_div_core u_div (
        .clk              (clk),
        .reset            (reset),
        .i_load           (w_accept),
        .i_step           (r_state == S_DIV),
        .i_op             (op),
        .i_word           (word),
        .i_a              (a),
        .i_b              (b),
        .o_special        (w_div_special),
        .o_special_result (w_div_special_result),
        .o_result         (w_div_result)
    );

    // Last-iteration index and the multiply result of the current step
    always_comb begin
        w_last       = r_word ? CNT_W'(MDU_ITER_32 - 1) : CNT_W'(MDU_ITER_64 - 1);
        w_prod_next  = r_prod + (r_mplier[0] ? r_mcand : {XLEN{1'b0}});
        w_mul_result = r_word ? sext32(w_prod_next[31:0]) : w_prod_next;
    end

    // Radix-2 shift-add multiplier; only the low XLEN product bits are kept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= {XLEN{1'b0}};
            r_mplier <= {XLEN{1'b0}};
            r_prod   <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_prod   <= {XLEN{1'b0}};
        end else if (r_state == S_MUL) begin
            r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
            r_prod   <= w_prod_next;
        end else begin
            r_prod   <= r_prod;
        end
    end

    // Sequencing FSM; flush beats stall, DONE holds while the stage is frozen
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_word   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= {CNT_W{1'b0}};
                    r_done <= 1'b0;
                    if (start) begin
                        r_word <= word;
                        if (op == MDU_MUL) begin
                            r_state <= S_MUL;
                        end else if (w_div_special) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_div_special_result;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (r_cnt == w_last) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_mul_result;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (r_cnt == w_last) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_div_result;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!stall) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table with expected results
// queued as a scoreboard, plus stall, flush and reset corner sequences.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    mdu_op_t     op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic        stall;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int compared   = 0;
    int mismatched = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        mdu_op_t     op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    mdu_sequencer #(.XLEN(64), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .word(word),
        .a(a), .b(b), .stall(stall), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op in cycle 0, then scramble the inputs to prove latching.
    task automatic start_op(input string name, input mdu_op_t o, input logic w,
                            input logic [63:0] va, input logic [63:0] vb);
        start = 1'b1; op = o; word = w; a = va; b = vb;
        #1;
        check({name, " busy_c0"}, 64'(busy), 64'd1);
        tick();
        start = 1'b0; op = MDU_DIVU; word = ~w;
        a = 64'hDEAD_BEEF_0BAD_F00D; b = 64'h0000_0000_0000_0003;
    endtask

    task automatic wait_done(input string name, output int cyc);
        logic busy_ok;
        busy_ok = 1'b1;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check({name, " busy_while_iter"}, 64'(busy_ok), 64'd1);
    endtask

    task automatic finish_check(input string name, input int cyc, input int exp_lat);
        logic [63:0] exp;
        exp = sb_q.pop_front();
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
        check({name, " result"}, result, exp);
    endtask

    task automatic run_op(input string name, input mdu_op_t o, input logic w,
                          input logic [63:0] va, input logic [63:0] vb,
                          input logic [63:0] exp, input int exp_lat);
        int cyc;
        sb_q.push_back(exp);
        start_op(name, o, w, va, vb);
        wait_done(name, cyc);
        finish_check(name, cyc, exp_lat);
        tick();
        check({name, " done_clears"}, 64'(done), 64'd0);
    endtask

    task automatic watch_no_done(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        check({name, " quiet"}, 64'(seen), 64'd0);
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{MDU_MUL,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        vecs[1]  = '{MDU_DIV,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[2]  = '{MDU_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[3]  = '{MDU_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[4]  = '{MDU_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vecs[5]  = '{MDU_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[6]  = '{MDU_MUL,  1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[7]  = '{MDU_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        vecs[8]  = '{MDU_REMU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'h10, 64'hF, 33};
        vecs[9]  = '{MDU_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[10] = '{MDU_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
        vecs[11] = '{MDU_REMU, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65};
        vecs[12] = '{MDU_REM,  1'b1, 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0005, 1};
        vecs[13] = '{MDU_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};

        reset = 1'b1; start = 1'b0; op = MDU_MUL; word = 1'b0;
        a = 64'd0; b = 64'd0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", result, 64'd0);

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].word,
                   vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // REMU held in DONE by stall for three cycles; start in DONE is ignored
        sb_q.push_back(64'd2);
        start_op("stall", MDU_REMU, 1'b0, 64'd100, 64'd7);
        wait_done("stall", cyc);
        finish_check("stall", cyc, 65);
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            if (k == 1) begin
                start = 1'b1; op = MDU_MUL; a = 64'd9; b = 64'd9;
            end
            tick();
            check($sformatf("stall hold%0d done", k), 64'(done), 64'd1);
            check($sformatf("stall hold%0d result", k), result, 64'd2);
            if (k == 2) start = 1'b0;
            if (k == 3) stall = 1'b0;
        end
        tick();
        check("stall release done", 64'(done), 64'd0);
        check("stall release busy", 64'(busy), 64'd0);

        // flush together with start in IDLE: op not accepted
        start = 1'b1; op = MDU_MUL; word = 1'b0; a = 64'd3; b = 64'd3; flush = 1'b1;
        #1;
        check("flush_start busy", 64'(busy), 64'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        watch_no_done("flush_start", 70);

        // flush in cycle 10 of a DIV
        start_op("flush_mid", MDU_DIV, 1'b0, 64'd1000, 64'd3);
        repeat (9) tick();
        flush = 1'b1;
        #1;
        check("flush_mid busy_in_flush", 64'(busy), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_mid idle_busy", 64'(busy), 64'd0);
        check("flush_mid idle_done", 64'(done), 64'd0);
        watch_no_done("flush_mid", 70);
        run_op("mul_after_flush", MDU_MUL, 1'b0, 64'd6, 64'd7, 64'd42, 65);

        // reset in cycle 20 of a DIV
        start_op("reset_mid", MDU_DIV, 1'b0, 64'd1000, 64'd3);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("reset_mid busy", 64'(busy), 64'd0);
        check("reset_mid done", 64'(done), 64'd0);
        check("reset_mid result", result, 64'd0);
        watch_no_done("reset_mid", 70);
        run_op("divu_after_reset", MDU_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);

        check("scoreboard empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
